dpu_scan_ctrl: RTL and testbench

Display scan controller that sequences the DPU through its four digit selects and drives active-low digit enables. It accepts new 16-bit values over a valid/ready handshake and applies them only at frame boundaries, so no torn frames reach the display. It inserts inter-digit blanking (anti-ghosting) and suppresses leading zeros using the DPU's dout feedback. It sits between the value producer and the DPU/7-segment pins.

---
 rtl/dpu_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_dpu_scan_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dpu_scan_ctrl.sv
// dpu_scan_ctrl: scans the DPU through digits 3..0 with blanking between
// digits, leading-zero suppression from dout feedback, and frame-boundary
// value updates through a one-deep pending slot.
`timescale 1ns/1ps

module dpu_scan_ctrl #(
  parameter int DIG_TICKS   = 50000,
  parameter int BLANK_TICKS = 500,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] val_in,
  input  logic        val_valid,
  output logic        val_ready,
  output logic [15:0] dpu_din,
  output logic [1:0]  dpu_dsel,
  input  logic [7:0]  dpu_dout,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLANK,
    SHOW
  } state_t;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIG_TICKS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      pending;
  logic             pend_full;
  logic             zflag;
  logic             load_now;
  logic             blank_digit;

  // The pending slot is drained only by a LOAD that is actually taken.
  assign load_now = (state == LOAD) && en && pend_full;

  // A non-zero digit position is dark while every higher digit was a zero.
  assign blank_digit = (dpu_dsel != 2'd0) && zflag && (dpu_dout == 8'd0);

  // Pending slot and producer handshake; draining wins over accepting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 16'd0;
      pend_full <= 1'b0;
      val_ready <= 1'b1;
    end else if (load_now) begin
      pend_full <= 1'b0;
      val_ready <= 1'b1;
    end else if (val_valid && val_ready) begin
      pending   <= val_in;
      pend_full <= 1'b1;
      val_ready <= 1'b0;
    end
  end

  // Scan sequencer; the lit/blank decision is registered as the blanking
  // interval ends, so the anode pattern appears exactly on the first SHOW cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      dpu_din    <= 16'd0;
      dpu_dsel   <= 2'd3;
      an         <= 4'hF;
      frame_done <= 1'b0;
      zflag      <= 1'b1;
    end else begin
      frame_done <= 1'b0;
      if (!en) begin
        state <= IDLE;
        an    <= 4'hF;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            an    <= 4'hF;
            cnt   <= '0;
            state <= LOAD;
          end
          LOAD: begin
            if (pend_full) begin
              dpu_din <= pending;
            end
            dpu_dsel <= 2'd3;
            zflag    <= 1'b1;
            an       <= 4'hF;
            cnt      <= '0;
            state    <= BLANK;
          end
          BLANK: begin
            if (cnt == BLANK_LAST) begin
              cnt   <= '0;
              state <= SHOW;
              if (!blank_digit) begin
                an    <= ~(4'b0001 << dpu_dsel);
                zflag <= 1'b0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              cnt <= '0;
              an  <= 4'hF;
              if (dpu_dsel != 2'd0) begin
                dpu_dsel <= dpu_dsel - 2'd1;
                state    <= BLANK;
              end else begin
                state      <= LOAD;
                frame_done <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            an    <= 4'hF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dpu_scan_ctrl.sv
// tb_dpu_scan_ctrl: table-driven frame checks with a scoreboard of expected
// frames, plus hand-written sequences for back-to-back offers, enable drop
// and asynchronous reset in the middle of a digit.
`timescale 1ns/1ps

module tb_dpu_scan_ctrl;

  typedef struct packed {
    logic [15:0] value;
    logic [15:0] an_pat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] val_in;
  logic        val_valid;
  logic        val_ready;
  logic [15:0] dpu_din;
  logic [1:0]  dpu_dsel;
  logic [7:0]  dpu_dout;
  logic [3:0]  an;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  time  t_pos = 0;
  vec_t sb[$];
  vec_t vecs[6];
  vec_t r;

  dpu_scan_ctrl #(
    .DIG_TICKS  (4),
    .BLANK_TICKS(2),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .val_in    (val_in),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .dpu_din   (dpu_din),
    .dpu_dsel  (dpu_dsel),
    .dpu_dout  (dpu_dout),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // DPU model: the selected hex nibble of din, combinationally.
  always_comb begin
    dpu_dout = 8'd0;
    case (dpu_dsel)
      2'd0: dpu_dout = {4'h0, dpu_din[3:0]};
      2'd1: dpu_dout = {4'h0, dpu_din[7:4]};
      2'd2: dpu_dout = {4'h0, dpu_din[11:8]};
      2'd3: dpu_dout = {4'h0, dpu_din[15:12]};
      default: dpu_dout = 8'd0;
    endcase
  end

  // Never more than one anode active.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("[TB] FAIL onehot_an: actual=%b required at most one low bit", an);
      end
    end
  end

  // Anode changes only on rising clock edges outside reset.
  always @(posedge clk) t_pos = $time;
  always @(an) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($time != t_pos) begin
        errors++;
        $display("[TB] FAIL an_glitch: actual change at %0t required at clock edge %0t", $time, t_pos);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Offer a value and wait (bounded) for the handshake to complete.
  task automatic applyStimulus(input logic [15:0] v);
    int n;
    n = 0;
    val_in = v;
    val_valid = 1'b1;
    while (val_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_in_time", {31'd0, n < 100}, 32'd1);
    @(negedge clk);
    val_valid = 1'b0;
    checkOutput("ready_drop", {31'd0, val_ready}, 32'd0);
  endtask

  task automatic popExpected(output vec_t e);
    checkOutput("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '0;
  endtask

  // Expected anodes on frame cycle i+2 (i = 0 is the first BLANK cycle).
  function automatic logic [3:0] expAn(input vec_t e, input int i);
    int k;
    k = 3 - i / 6;
    if (i % 6 < 2) return 4'hF;
    return e.an_pat[k*4 +: 4];
  endfunction

  // Check the rest of a frame from index first, then the closing LOAD.
  task automatic observeFrame(input vec_t e, input int first);
    for (int i = first; i < 24; i++) begin
      @(negedge clk);
      checkOutput($sformatf("an_cyc%0d_%h", i + 2, e.value), {28'd0, an}, {28'd0, expAn(e, i)});
      checkOutput($sformatf("fd_low_cyc%0d", i + 2), {31'd0, frame_done}, 32'd0);
    end
    @(negedge clk);
    checkOutput("frame_done_pulse", {31'd0, frame_done}, 32'd1);
    checkOutput("load_an", {28'd0, an}, 32'hF);
    checkOutput($sformatf("din_%h", e.value), {16'd0, dpu_din}, {16'd0, e.value});
  endtask

  initial begin
    int n;
    vecs[0] = '{value: 16'h1234, an_pat: 16'h7BDE};
    vecs[1] = '{value: 16'h0007, an_pat: 16'hFFFE};
    vecs[2] = '{value: 16'h0000, an_pat: 16'hFFFE};
    vecs[3] = '{value: 16'h1005, an_pat: 16'h7BDE};
    vecs[4] = '{value: 16'h0030, an_pat: 16'hFFDE};
    vecs[5] = '{value: 16'h0100, an_pat: 16'hFBDE};

    rst_n = 1'b0;
    en = 1'b0;
    val_in = 16'd0;
    val_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_an", {28'd0, an}, 32'hF);
    checkOutput("rst_dsel", {30'd0, dpu_dsel}, 32'd3);
    checkOutput("rst_ready", {31'd0, val_ready}, 32'd1);
    checkOutput("rst_fd", {31'd0, frame_done}, 32'd0);
    checkOutput("rst_din", {16'd0, dpu_din}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames: load each value while idle, then scan one frame.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].value);
      sb.push_back(vecs[v]);
      en = 1'b1;
      @(negedge clk);
      checkOutput("first_load_an", {28'd0, an}, 32'hF);
      checkOutput("first_load_no_fd", {31'd0, frame_done}, 32'd0);
      popExpected(r);
      observeFrame(r, 0);
      en = 1'b0;
    end

    // Back-to-back offers: first fills pending, second stalls until LOAD.
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    applyStimulus(16'h0011);
    sb.push_back('{value: 16'h0011, an_pat: 16'hFFDE});
    val_in = 16'h0022;
    val_valid = 1'b1;
    n = 0;
    while (frame_done !== 1'b1 && n < 40) begin
      @(negedge clk);
      checkOutput("b2b_stall", {31'd0, val_ready}, 32'd0);
      n++;
    end
    checkOutput("b2b_frame_end", {31'd0, frame_done}, 32'd1);
    @(negedge clk);
    checkOutput("b2b_ready_back", {31'd0, val_ready}, 32'd1);
    checkOutput("b2b_din11", {16'd0, dpu_din}, 32'h0011);
    checkOutput("b2b_an_c2", {28'd0, an}, 32'hF);
    @(negedge clk);
    checkOutput("b2b_22_taken", {31'd0, val_ready}, 32'd0);
    checkOutput("b2b_an_c3", {28'd0, an}, 32'hF);
    val_valid = 1'b0;
    sb.push_back('{value: 16'h0022, an_pat: 16'hFFDE});
    popExpected(r);
    observeFrame(r, 2);
    popExpected(r);
    observeFrame(r, 0);

    // Enable dropped while digit 2 is lit, then restarted.
    en = 1'b0;
    @(negedge clk);
    applyStimulus(16'h1234);
    sb.push_back(vecs[0]);
    en = 1'b1;
    @(negedge clk);
    popExpected(r);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("pre_drop_an%0d", i + 2), {28'd0, an}, {28'd0, expAn(r, i)});
    end
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checkOutput("drop_an_off", {28'd0, an}, 32'hF);
      checkOutput("drop_no_fd", {31'd0, frame_done}, 32'd0);
    end
    en = 1'b1;
    @(negedge clk);
    checkOutput("restart_load_an", {28'd0, an}, 32'hF);
    checkOutput("restart_no_fd", {31'd0, frame_done}, 32'd0);
    observeFrame(r, 0);

    // Asynchronous reset while digit 0 is lit, with a value pending.
    applyStimulus(16'h5555);
    n = 0;
    while (an !== 4'b1110 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("digit0_reached", {28'd0, an}, 32'hE);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_an", {28'd0, an}, 32'hF);
    checkOutput("async_rst_dsel", {30'd0, dpu_dsel}, 32'd3);
    checkOutput("async_rst_ready", {31'd0, val_ready}, 32'd1);
    checkOutput("async_rst_din", {16'd0, dpu_din}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_an", {28'd0, an}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
